inst_loader: RTL and testbench

Write-side loader for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions. It writes each instruction into the instruction memory's write port and holds the LEGv8 core in reset until a complete, checksum-verified image has been loaded. It sits between the host/boot byte source (UART or testbench) and the instruction memory.

---
 rtl/inst_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: write-side loader for the instruction memory.
//
// Accepts a framed byte stream over a valid/ready handshake:
//   CNT_LO, CNT_HI (16-bit little-endian word count N), 4*N data bytes, 1 checksum byte.
// Data bytes are packed little-endian into 32-bit instructions and written to the
// instruction memory one word at a time. The checksum is the XOR of all data bytes.
// The core is held in reset (cpu_rst_n=0) until a complete, verified image is loaded.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous restart to the header state (wins over a same-cycle byte)
//   s_data     stream byte
//   s_valid    byte valid
//   s_ready    loader can accept a byte (registered, never depends on s_valid)
//   wr_en      one-cycle instruction-memory write strobe
//   wr_addr    word index of the write
//   wr_data    instruction word
//   done       image loaded and checksum matched (sticky until clr/rst_n)
//   error      length overflow or checksum mismatch (sticky until clr/rst_n)
//   cpu_rst_n  core reset release, equals done
module inst_loader #(
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned INST_SIZE = 32,
  parameter int unsigned AW        = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [INST_SIZE-1:0] wr_data,
  output logic                 done,
  output logic                 error,
  output logic                 cpu_rst_n
);

  typedef enum logic [2:0] {
    StCntLo,
    StCntHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e               state_q;
  logic [15:0]          cnt_q;      // word count N from the header
  logic [AW:0]          word_q;     // words written so far; one extra bit so N == SIZE fits
  logic [1:0]           byte_q;     // byte position inside the current word
  logic [23:0]          shift_q;    // first three bytes of the current word
  logic [7:0]           xor_q;      // running checksum over data bytes
  logic                 s_ready_q;
  logic                 wr_en_q;
  logic [AW-1:0]        wr_addr_q;
  logic [INST_SIZE-1:0] wr_data_q;
  logic                 done_q;
  logic                 error_q;

  logic        accept;
  logic [15:0] cnt_full;
  logic [AW:0] word_nxt;

  assign accept   = s_valid && s_ready_q;
  assign cnt_full = {s_data, cnt_q[7:0]};
  assign word_nxt = word_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCntLo;
      cnt_q     <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      xor_q     <= '0;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else if (clr) begin
      // Partial word and counters are discarded; memory contents and the last
      // write address/data are left untouched.
      state_q   <= StCntLo;
      cnt_q     <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      xor_q     <= '0;
      s_ready_q <= 1'b1;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      // Ready follows the state; transitions into the terminal states override below.
      s_ready_q <= (state_q != StDone) && (state_q != StErr);
      if (accept) begin
        unique case (state_q)
          StCntLo: begin
            cnt_q[7:0] <= s_data;
            state_q    <= StCntHi;
          end
          StCntHi: begin
            cnt_q[15:8] <= s_data;
            if (32'(cnt_full) > SIZE) begin
              state_q   <= StErr;
              error_q   <= 1'b1;
              s_ready_q <= 1'b0;
            end else if (cnt_full == 16'd0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
          StData: begin
            xor_q   <= xor_q ^ s_data;
            shift_q <= {s_data, shift_q[23:8]};
            byte_q  <= byte_q + 2'd1;
            if (byte_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= word_q[AW-1:0];
              wr_data_q <= INST_SIZE'({s_data, shift_q});
              word_q    <= word_nxt;
              if (32'(word_nxt) == 32'(cnt_q)) begin
                state_q <= StCsum;
              end
            end
          end
          StCsum: begin
            s_ready_q <= 1'b0;
            if (s_data == xor_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
          default: begin
            // StDone / StErr never accept (s_ready is low).
          end
        endcase
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = done_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: per-byte vector table plus hand-written
// sequences for gaps, clr mid-word, a full-size image and asynchronous reset.
module tb_inst_loader;

  localparam int unsigned SIZE = 1024;
  localparam int unsigned AW   = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          done;
  logic          error;
  logic          cpu_rst_n;

  inst_loader #(.SIZE(SIZE), .INST_SIZE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .error     (error),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: one entry per wr_en pulse, sampled away from the active edge.
  logic [41:0] wq[$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
  end

  typedef struct {
    logic        clr;
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic v, input logic [7:0] d, input logic rdy,
                     input logic we, input logic [9:0] a, input logic [31:0] wd,
                     input logic dn, input logic er);
    vec_t t;
    t.clr = c; t.valid = v; t.data = d; t.rdy = rdy; t.we = we;
    t.addr = a; t.wd = wd; t.done = dn; t.err = er;
    vecs.push_back(t);
  endtask

  task automatic step(input logic c, input logic v, input logic [7:0] d);
    clr = c; s_valid = v; s_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic we,
                            input logic [9:0] a, input logic [31:0] wd,
                            input logic dn, input logic er);
    check({tag, " s_ready"}, 32'(s_ready), 32'(rdy));
    check({tag, " wr_en"}, 32'(wr_en), 32'(we));
    check({tag, " wr_addr"}, 32'(wr_addr), 32'(a));
    check({tag, " wr_data"}, wr_data, wd);
    check({tag, " done"}, 32'(done), 32'(dn));
    check({tag, " error"}, 32'(error), 32'(er));
    check({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'(dn));
  endtask

  function automatic logic [7:0] img_byte(input int w, input int j);
    return 8'((w * 7) + (j * 13) + 1);
  endfunction

  // Nominal two-word frame; checksum = 13^00^A0^D2^1F^20^03^D5 = 0x88.
  logic [7:0] nom[11];

  initial begin
    logic [7:0] x;
    int bad;
    nom = '{8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hD2, 8'h1F, 8'h20, 8'h03, 8'hD5, 8'h88};

    // ---------------- vector table ----------------
    add(0, 0, 8'h00, 1, 0, 0, 32'h0, 0, 0);                // ready rises after reset cycle
    add(0, 1, 8'h02, 1, 0, 0, 32'h0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 0);
    add(0, 1, 8'h13, 1, 0, 0, 32'h0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 0);
    add(0, 1, 8'hA0, 1, 0, 0, 32'h0, 0, 0);
    add(0, 1, 8'hD2, 1, 1, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'h1F, 1, 0, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'h20, 1, 0, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'h03, 1, 0, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'hD5, 1, 1, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h88, 0, 0, 1, 32'hD503201F, 1, 0);
    add(0, 1, 8'h55, 0, 0, 1, 32'hD503201F, 1, 0);         // done is sticky
    add(1, 1, 8'h02, 1, 0, 1, 32'hD503201F, 0, 0);         // clr: byte dropped, outputs hold
    // checksum mismatch
    add(0, 1, 8'h02, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h00, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h13, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h00, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'hA0, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'hD2, 1, 1, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'h1F, 1, 0, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'h20, 1, 0, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'h03, 1, 0, 0, 32'hD2A00013, 0, 0);
    add(0, 1, 8'hD5, 1, 1, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h00, 0, 0, 1, 32'hD503201F, 0, 1);
    add(0, 1, 8'h88, 0, 0, 1, 32'hD503201F, 0, 1);         // error is sticky
    add(1, 0, 8'h00, 1, 0, 1, 32'hD503201F, 0, 0);
    // N = 0
    add(0, 1, 8'h00, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h00, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h00, 0, 0, 1, 32'hD503201F, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 32'hD503201F, 0, 0);
    // N = 1025: overflow right after CNT_HI
    add(0, 1, 8'h01, 1, 0, 1, 32'hD503201F, 0, 0);
    add(0, 1, 8'h04, 0, 0, 1, 32'hD503201F, 0, 1);
    add(0, 1, 8'h13, 0, 0, 1, 32'hD503201F, 0, 1);

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 32'h0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("ready before first edge", 32'(s_ready), 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].valid, vecs[i].data);
      check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wd,
                 vecs[i].done, vecs[i].err);
    end

    // ---------------- gaps inside words ----------------
    step(1, 0, 8'h00);
    wq.delete();
    for (int k = 0; k < 11; k++) begin
      int g;
      g = (k % 2 == 0) ? 1 : int'($urandom_range(0, 2));
      repeat (g) step(0, 0, 8'($urandom));
      step(0, 1, nom[k]);
    end
    check("gaps write count", 32'(wq.size()), 32'd2);
    if (wq.size() >= 2) begin
      check("gaps word0", wq[0][31:0], 32'hD2A00013);
      check("gaps addr0", 32'(wq[0][41:32]), 32'd0);
      check("gaps word1", wq[1][31:0], 32'hD503201F);
      check("gaps addr1", 32'(wq[1][41:32]), 32'd1);
    end
    check("gaps done", 32'(done), 32'd1);

    // ---------------- clr mid-word with a valid byte ----------------
    step(1, 0, 8'h00);
    wq.delete();
    step(0, 1, 8'h02); step(0, 1, 8'h00); step(0, 1, 8'h13); step(0, 1, 8'h00);
    step(1, 1, 8'hFF);
    check("clr ready", 32'(s_ready), 32'd1);
    check("clr done", 32'(done), 32'd0);
    step(0, 1, 8'h01); step(0, 1, 8'h00);
    step(0, 1, 8'h11); step(0, 1, 8'h22); step(0, 1, 8'h33); step(0, 1, 8'h44);
    step(0, 1, 8'h44);                                      // 11^22^33^44
    check("clr write count", 32'(wq.size()), 32'd1);
    if (wq.size() >= 1) begin
      check("clr word", wq[0][31:0], 32'h44332211);
      check("clr addr", 32'(wq[0][41:32]), 32'd0);
    end
    check("clr frame done", 32'(done), 32'd1);

    // ---------------- full image N = SIZE ----------------
    step(1, 0, 8'h00);
    wq.delete();
    step(0, 1, 8'h00); step(0, 1, 8'h04);
    x = 8'h00;
    for (int w = 0; w < int'(SIZE); w++) begin
      for (int j = 0; j < 4; j++) begin
        x = x ^ img_byte(w, j);
        step(0, 1, img_byte(w, j));
      end
    end
    step(0, 1, x);
    check("full write count", 32'(wq.size()), SIZE);
    bad = 0;
    foreach (wq[w]) begin
      if (wq[w] !== {10'(w), img_byte(w, 3), img_byte(w, 2), img_byte(w, 1), img_byte(w, 0)})
        bad++;
    end
    check("full bad words", 32'(bad), 32'd0);
    check("full last addr", 32'(wr_addr), 32'd1023);
    check("full done", 32'(done), 32'd1);
    check("full error", 32'(error), 32'd0);

    // ---------------- async reset in S_DATA ----------------
    step(1, 0, 8'h00);
    wq.delete();
    step(0, 1, 8'h01); step(0, 1, 8'h00); step(0, 1, 8'hAA); step(0, 1, 8'hBB);
    s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 0, 0, 0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    check("post-reset ready", 32'(s_ready), 32'd1);
    step(0, 1, 8'h01); step(0, 1, 8'h00);
    step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h03); step(0, 1, 8'h04);
    step(0, 1, 8'h04);                                      // 01^02^03^04
    check("post-reset write count", 32'(wq.size()), 32'd1);
    if (wq.size() >= 1) begin
      check("post-reset word", wq[0][31:0], 32'h04030201);
      check("post-reset addr", 32'(wq[0][41:32]), 32'd0);
    end
    check("post-reset done", 32'(done), 32'd1);
    check("post-reset cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
